reg_file_wb: RTL and testbench



---
 rtl/reg_file_wb_pkg.sv | 14 +
 rtl/regfile_read_port.sv | 32 +++
 rtl/reg_file_wb.sv | 69 ++++++
 tb/tb_reg_file_wb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the write-back register file (R0-R14; index 15 is the PC).
package reg_file_wb_pkg;

  localparam int unsigned NUM_ARCH_REGS = 15;
  localparam int unsigned REG_ADDR_W    = 4;
  localparam int unsigned DATA_W        = 32;
  localparam logic [3:0]  PC_IDX        = 4'd15;

  // Test programs rely on Ri holding i after reset.
  function automatic logic [DATA_W-1:0] reset_val(input int unsigned i);
    return DATA_W'(i);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port: index-15 zero override plus optional write-through
// bypass, enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_BYPASS_EN
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
`endif
  output logic [DATA_W-1:0] rd
);
  import reg_file_wb_pkg::*;

  always_comb begin
    rd = stored;
    if (src == ADDR_W'(PC_IDX)) begin
      rd = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // src != PC here, so a match also implies wb_dest != PC
    else if (!rst && wb_en && (wb_dest == src)) begin
      rd = wb_value;
    end
`endif
  end

endmodule

// File: rtl/reg_file_wb.sv
// Register file R0-R14 terminating the write-back stage, two combinational read
// ports. Optional same-cycle bypass via macro REGFILE_BYPASS_EN.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] WB_Dest,
  input  logic [DATA_W-1:0] WB_Value,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2
);
  import reg_file_wb_pkg::*;

  logic [DATA_W-1:0] regs [NUM_ARCH_REGS];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
        regs[i] <= DATA_W'(reset_val(i));
      end
    end else if (WB_EN && (WB_Dest != ADDR_W'(PC_IDX))) begin
      for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
        if (WB_Dest == ADDR_W'(i)) regs[i] <= WB_Value;
      end
    end
  end

  // Loop lookup keeps index 15 from ever addressing past the array.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int unsigned i = 0; i < NUM_ARCH_REGS; i++) begin
      if (src1 == ADDR_W'(i)) stored1 = regs[i];
      if (src2 == ADDR_W'(i)) stored2 = regs[i];
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .src      (src1),
    .stored   (stored1),
`ifdef REGFILE_BYPASS_EN
    .rst      (rst),
    .wb_en    (WB_EN),
    .wb_dest  (WB_Dest),
    .wb_value (WB_Value),
`endif
    .rd       (reg1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .src      (src2),
    .stored   (stored2),
`ifdef REGFILE_BYPASS_EN
    .rst      (rst),
    .wb_en    (WB_EN),
    .wb_dest  (WB_Dest),
    .wb_value (WB_Value),
`endif
    .rd       (reg2)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed test-plan steps then random
// traffic against an array-based reference model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2;
  logic        WB_EN;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic [31:0] reg1, reg2;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [15];

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .src1     (src1),
    .src2     (src2),
    .WB_EN    (WB_EN),
    .WB_Dest  (WB_Dest),
    .WB_Value (WB_Value),
    .reg1     (reg1),
    .reg2     (reg2)
  );

  function automatic logic [31:0] expect_rd(input logic [3:0] s, input logic r,
                                            input logic en, input logic [3:0] d,
                                            input logic [31:0] v);
    if (s == 4'd15) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!r && en && d == s) return v;
`endif
    return model[s];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, optionally check both ports before the edge,
  // then advance the model across the edge.
  task automatic cycle(input string tag, input logic r, input logic en,
                       input logic [3:0] d, input logic [31:0] v,
                       input logic [3:0] s1, input logic [3:0] s2, input bit chk);
    @(negedge clk);
    rst = r; WB_EN = en; WB_Dest = d; WB_Value = v; src1 = s1; src2 = s2;
    #1;
    if (chk) begin
      check({tag, "_reg1"}, reg1, expect_rd(s1, r, en, d, v));
      check({tag, "_reg2"}, reg2, expect_rd(s2, r, en, d, v));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 15; i++) model[i] = 32'(i);
    end else if (en && d != 4'd15) begin
      model[d] = v;
    end
  endtask

  task automatic read(input string tag, input logic [3:0] s1, input logic [3:0] s2);
    cycle(tag, 1'b0, 1'b0, 4'd0, 32'h0, s1, s2, 1'b1);
  endtask

  initial begin
    rst = 1'b1; WB_EN = 1'b0; WB_Dest = '0; WB_Value = '0; src1 = '0; src2 = '0;

    // reset held for two edges; array is undefined before the first one
    cycle("rst_a", 1'b1, 1'b1, 4'd4, 32'hFFFF, 4'd4, 4'd5, 1'b0);
    cycle("rst_b", 1'b1, 1'b1, 4'd4, 32'hFFFF, 4'd4, 4'd5, 1'b1);
    check("rst_r5_const", model[5], 32'd5);
    read("rst_read", 4'd5, 4'd14);
    check("rst_r14_abs", reg2, 32'd14);
    read("rst_pc", 4'd15, 4'd0);
    check("rst_pc_abs", reg1, 32'h0);

    // basic write
    cycle("wr3", 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd2, 1'b1);
    read("wr3_rd", 4'd3, 4'd2);
    check("wr3_abs", reg1, 32'hDEADBEEF);
    read("wr3_nbr", 4'd4, 4'd2);

    // gated and PC-destined writes
    cycle("gate7", 1'b0, 1'b0, 4'd7, 32'h1234, 4'd7, 4'd7, 1'b1);
    read("gate7_rd", 4'd7, 4'd8);
    check("gate7_abs", reg1, 32'd7);
    cycle("pcwr", 1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF, 4'd15, 4'd0, 1'b1);
    for (int i = 0; i < 16; i += 2) read("sweep", 4'(i), 4'(i + 1));

    // collision on R6
    cycle("coll6", 1'b0, 1'b1, 4'd6, 32'hA5A5_0000, 4'd6, 4'd6, 1'b1);
`ifdef REGFILE_BYPASS_EN
    check("coll6_byp_abs", reg1, 32'hA5A5_0000);
`else
    check("coll6_old_abs", reg1, 32'd6);
`endif
    read("coll6_after", 4'd6, 4'd6);
    check("coll6_after_abs", reg2, 32'hA5A5_0000);

    // reset mid-stream beats the pending write and any bypass
    cycle("wr9", 1'b0, 1'b1, 4'd9, 32'h55, 4'd1, 4'd2, 1'b1);
    read("wr9_rd", 4'd9, 4'd9);
    check("wr9_abs", reg1, 32'h55);
    cycle("rst9", 1'b1, 1'b1, 4'd9, 32'h77, 4'd9, 4'd9, 1'b1);
    check("rst9_nobyp_abs", reg1, 32'h55);
    read("rst9_rd", 4'd9, 4'd3);
    check("rst9_abs", reg1, 32'd9);

    // back-to-back writes
    cycle("b2b_a", 1'b0, 1'b1, 4'd1, 32'h10, 4'd1, 4'd2, 1'b1);
    cycle("b2b_b", 1'b0, 1'b1, 4'd1, 32'h20, 4'd1, 4'd2, 1'b1);
    cycle("b2b_c", 1'b0, 1'b1, 4'd2, 32'h30, 4'd1, 4'd2, 1'b1);
    read("b2b_rd", 4'd1, 4'd2);
    check("b2b_r1_abs", reg1, 32'h20);
    check("b2b_r2_abs", reg2, 32'h30);

    // random traffic, biased towards collisions
    for (int n = 0; n < 400; n++) begin
      logic        r, en;
      logic [3:0]  d, s1, s2;
      logic [31:0] v;
      r  = ($urandom_range(0, 39) == 0);
      en = 1'($urandom);
      d  = 4'($urandom_range(0, 15));
      v  = $urandom;
      s1 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      s2 = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      cycle("rand", r, en, d, v, s1, s2, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
